image_writer: RTL

IMAGE_WRITER -- requirements
Module: image_writer

---
 rtl/image_pkg.sv | 26 ++
 rtl/pixel_fifo.sv | 49 ++++
 rtl/image_writer.sv | 117 +++++++++++
 3 files changed

// File: rtl/image_pkg.sv
// Shared types for the image writer: FSM state, packed 24-bit pixel, channel bit positions.
// Pixel packing is {r, g, b}, with red in the top byte.
package image_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [23:0] pixel_t;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    function automatic pixel_t pack_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pixel_t p;
        p = '0;
        p[R_LSB +: 8] = r;
        p[G_LSB +: 8] = g;
        p[B_LSB +: 8] = b;
        return p;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO: dout is the head entry whenever empty is low.
// Push and pop in the same cycle on a full FIFO are both honoured; flush empties it.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout  = store[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/image_writer.sv
// Captures one frame of processed pixels into a frame buffer, buffering across mem_ready stalls.
// Define IMAGE_WRITER_BOTTOM_UP_EN for BMP-style bottom-up row addressing.
module image_writer
    import image_pkg::*;
#(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic        mem_wr_en,
    output logic [15:0] mem_addr,
    output logic [23:0] mem_data,
    input  logic        mem_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow
);

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  col;
    logic [8:0]  row;
    logic [15:0] row_eff;
    pixel_t      head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        flush;
    logic        last_pix;
    logic        run;

    assign run       = (state == ST_RUN);
    assign mem_wr_en = run && !fifo_empty;
    assign pop       = mem_wr_en && mem_ready;
    // A full FIFO still takes a pixel when the head leaves in the same cycle.
    assign push      = run && pix_valid && (!fifo_full || pop);
    assign flush     = (state == ST_DONE);
    assign last_pix  = (col == 9'(IMG_W - 1)) && (row == 9'(IMG_H - 1));
    assign busy      = run;
    assign frame_done = (state == ST_DONE);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .din   (pack_pixel(pix_r, pix_g, pix_b)),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (pop && last_pix) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counters only move on completed writes, so the address holds through a stall.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (col == 9'(IMG_W - 1)) begin
                col <= '0;
                row <= row + 9'd1;
            end else begin
                col <= col + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            overflow <= 1'b0;
        end else if (run && pix_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef IMAGE_WRITER_BOTTOM_UP_EN
    assign row_eff = 16'(IMG_H - 1) - 16'(row);
`else
    assign row_eff = 16'(row);
`endif

    assign mem_addr = mem_wr_en ? (row_eff * 16'(IMG_W) + 16'(col)) : 16'd0;
    assign mem_data = mem_wr_en ? head : 24'd0;

endmodule
